// File: rtl/rom_fetch_responder_pkg.sv
// Shared definitions for the fetch-bus responders: machine-cycle slots,
// tracker state encoding and bus nibble width.
package rom_fetch_responder_pkg;
  localparam int NIB_W = 4;

  localparam logic [2:0] CY_A1 = 3'd0;
  localparam logic [2:0] CY_A2 = 3'd1;
  localparam logic [2:0] CY_A3 = 3'd2;
  localparam logic [2:0] CY_M1 = 3'd3;
  localparam logic [2:0] CY_M2 = 3'd4;
  localparam logic [2:0] CY_X1 = 3'd5;
  localparam logic [2:0] CY_X2 = 3'd6;
  localparam logic [2:0] CY_X3 = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/rom_fetch_responder_tracker.sv
// Sync-driven machine-cycle tracker: IDLE/RUN FSM, 8-slot counter and
// a one-clock error pulse when sync arrives outside X3.
module fetch_cycle_tracker
  import rom_fetch_responder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sync,
  output logic [2:0] cycle,
  output logic       run,
  output logic       syncErr
);

  fetch_state_e state_q, state_d;
  logic [2:0]   cycle_q, cycle_d;
  logic         err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cycle_q <= CY_A1;
      syncErr <= 1'b0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      syncErr <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sync) begin
          state_d = ST_RUN;
          cycle_d = CY_A1;
        end
      end
      ST_RUN: begin
        if (sync) begin
          cycle_d = CY_A1;
          err_d   = (cycle_q != CY_X3);
        end else begin
          cycle_d = cycle_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cycle = cycle_q;
  assign run   = (state_q == ST_RUN);

endmodule

// File: rtl/rom_fetch_responder.sv
// ROM-side instruction-fetch responder: latches the 12-bit address over
// A1..A3 and returns the addressed opcode byte as two nibbles in M1/M2.
module rom_fetch_responder
  import rom_fetch_responder_pkg::*;
#(
  parameter logic [NIB_W-1:0] CHIP_ID = 4'h0,
  parameter int               MEM_AW  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync,
  input  logic [NIB_W-1:0]  busIn,
  output logic [NIB_W-1:0]  busOut,
  output logic              busOe,
  output logic [MEM_AW-1:0] memAddr,
  input  logic [7:0]        memData,
  output logic [2:0]        cycleOut,
  output logic              selected,
  output logic              fetchDone,
  output logic              syncErr
);

  logic [2:0]       cycle;
  logic             run;
  logic [NIB_W-1:0] aLow, aMid;

  fetch_cycle_tracker u_trk (
    .clk     (clk),
    .rst     (rst),
    .sync    (sync),
    .cycle   (cycle),
    .run     (run),
    .syncErr (syncErr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aLow      <= '0;
      aMid      <= '0;
      memAddr   <= '0;
      selected  <= 1'b0;
      fetchDone <= 1'b0;
    end else begin
      // Marks X1 of a fetch whose data phase completed without a resync.
      fetchDone <= run && selected && (cycle == CY_M2) && !sync;
      if (run) begin
        if (sync) begin
          selected <= 1'b0;
        end else begin
          case (cycle)
            CY_A1: aLow <= busIn;
            CY_A2: aMid <= busIn;
            CY_A3: begin
              memAddr  <= {aMid, aLow};
              selected <= (busIn == CHIP_ID);
            end
            CY_X3:   selected <= 1'b0;
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    busOut = '0;
    if (cycle == CY_M1)      busOut = memData[7:4];
    else if (cycle == CY_M2) busOut = memData[3:0];
  end

  assign busOe    = run && selected && ((cycle == CY_M1) || (cycle == CY_M2));
  assign cycleOut = cycle;

endmodule

// File: tb/tb_rom_fetch_responder.sv
// Bench for rom_fetch_responder: ROM model, scoreboard of expected opcode
// nibbles popped whenever the DUT drives the bus.
module tb_rom_fetch_responder;
  logic       clk = 1'b0;
  logic       rst;
  logic       sync;
  logic [3:0] busIn;
  logic [3:0] busOut;
  logic       busOe;
  logic [7:0] memAddr;
  logic [7:0] memData;
  logic [2:0] cycleOut;
  logic       selected;
  logic       fetchDone;
  logic       syncErr;

  logic [7:0] rom [256];
  logic [3:0] sbq [$];
  logic [7:0] last_addr;
  int n_vec = 0;
  int n_err = 0;

  rom_fetch_responder #(.CHIP_ID(4'h0), .MEM_AW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .sync      (sync),
    .busIn     (busIn),
    .busOut    (busOut),
    .busOe     (busOe),
    .memAddr   (memAddr),
    .memData   (memData),
    .cycleOut  (cycleOut),
    .selected  (selected),
    .fetchDone (fetchDone),
    .syncErr   (syncErr)
  );

  always #5 clk = ~clk;
  assign memData = rom[memAddr];

  // Every driven nibble must match the next expected one, in order.
  always @(negedge clk) begin
    if (busOe === 1'b1) begin
      n_vec++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL bus_unexpected: drove %h with nothing expected", busOut);
      end else begin
        logic [3:0] exp;
        exp = sbq.pop_front();
        if (busOut !== exp) begin
          n_err++;
          $display("FAIL bus_data: got %h want %h (cycle %0d)", busOut, exp, cycleOut);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: already in A1; 1: sync into A1; 2: free-running wrap into A1
  task automatic enter(input int mode);
    if (mode == 1) begin
      sync = 1'b1; tick(); sync = 1'b0;
    end else if (mode == 2) begin
      n_vec++;
      if (cycleOut !== 3'd7) begin n_err++; $display("FAIL pre_wrap_cycle: got %0d want 7", cycleOut); end
      tick();
    end
    n_vec++;
    if (cycleOut !== 3'd0) begin n_err++; $display("FAIL a1_cycle: got %0d want 0", cycleOut); end
  endtask

  // Drives A1..A3, leaves the bench 1ns into M1.
  task automatic addr_phase(input logic [11:0] a, input bit sel, input int npush);
    logic [7:0] d;
    busIn = a[3:0]; tick();
    n_vec++;
    if (syncErr !== 1'b0) begin n_err++; $display("FAIL syncerr_idle: got %b want 0", syncErr); end
    n_vec++;
    if (memAddr !== last_addr) begin n_err++; $display("FAIL memaddr_hold_a2: got %h want %h", memAddr, last_addr); end
    busIn = a[7:4]; tick();
    n_vec++;
    if (memAddr !== last_addr) begin n_err++; $display("FAIL memaddr_hold_a3: got %h want %h", memAddr, last_addr); end
    busIn = a[11:8];
    d = rom[a[7:0]];
    if (npush > 0) sbq.push_back(d[7:4]);
    if (npush > 1) sbq.push_back(d[3:0]);
    tick();
    busIn = 4'h0;
    last_addr = a[7:0];
    n_vec++;
    if (memAddr !== a[7:0]) begin n_err++; $display("FAIL memaddr_m1: got %h want %h", memAddr, a[7:0]); end
    n_vec++;
    if (cycleOut !== 3'd3) begin n_err++; $display("FAIL m1_cycle: got %0d want 3", cycleOut); end
    n_vec++;
    if (busOe !== sel) begin n_err++; $display("FAIL oe_m1: got %b want %b", busOe, sel); end
    n_vec++;
    if (selected !== sel) begin n_err++; $display("FAIL selected_m1: got %b want %b", selected, sel); end
  endtask

  // M1 -> M2 -> X1 -> X2 -> X3
  task automatic data_phase(input bit sel);
    tick();
    n_vec++;
    if (busOe !== sel) begin n_err++; $display("FAIL oe_m2: got %b want %b", busOe, sel); end
    tick();
    n_vec++;
    if (fetchDone !== sel) begin n_err++; $display("FAIL fetchdone_x1: got %b want %b", fetchDone, sel); end
    n_vec++;
    if (busOe !== 1'b0) begin n_err++; $display("FAIL oe_x1: got %b want 0", busOe); end
    tick();
    n_vec++;
    if (fetchDone !== 1'b0) begin n_err++; $display("FAIL fetchdone_x2: got %b want 0", fetchDone); end
    tick();
    n_vec++;
    if (cycleOut !== 3'd7 || busOe !== 1'b0) begin
      n_err++; $display("FAIL x3_state: got cycle %0d oe %b want cycle 7 oe 0", cycleOut, busOe);
    end
  endtask

  task automatic fetch(input logic [11:0] a, input bit sel, input int mode);
    enter(mode);
    addr_phase(a, sel, sel ? 2 : 0);
    data_phase(sel);
  endtask

  task automatic test_reset();
    rst = 1'b1; sync = 1'b0; busIn = 4'h0;
    repeat (3) tick();
    n_vec++;
    if ({busOe, busOut, memAddr, cycleOut, selected, fetchDone, syncErr} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got oe %b out %h addr %h cyc %0d sel %b fd %b se %b want all 0",
               busOe, busOut, memAddr, cycleOut, selected, fetchDone, syncErr);
    end
    rst = 1'b0;
    last_addr = 8'h00;
    repeat (2) tick();
    n_vec++;
    if (cycleOut !== 3'd0 || busOe !== 1'b0) begin
      n_err++; $display("FAIL idle_hold: got cycle %0d oe %b want 0 0", cycleOut, busOe);
    end
  endtask

  task automatic test_basic();        fetch(12'h0A5, 1'b1, 1); endtask
  task automatic test_unselected();   fetch(12'h2A5, 1'b0, 1); endtask

  task automatic test_back_to_back();
    fetch(12'h00F, 1'b1, 1);
    fetch(12'h010, 1'b1, 1);
  endtask

  task automatic test_sync_abort();
    enter(1);
    addr_phase(12'h033, 1'b1, 1);
    sync = 1'b1; tick(); sync = 1'b0;
    n_vec++;
    if (cycleOut !== 3'd0) begin n_err++; $display("FAIL resync_cycle: got %0d want 0", cycleOut); end
    n_vec++;
    if (syncErr !== 1'b1) begin n_err++; $display("FAIL syncerr_pulse: got %b want 1", syncErr); end
    n_vec++;
    if (busOe !== 1'b0 || selected !== 1'b0) begin
      n_err++; $display("FAIL resync_abort: got oe %b sel %b want 0 0", busOe, selected);
    end
    addr_phase(12'h044, 1'b1, 2);
    data_phase(1'b1);
  endtask

  task automatic test_reset_midfetch();
    int bad;
    enter(1);
    addr_phase(12'h0C7, 1'b1, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if (busOe !== 1'b0 || cycleOut !== 3'd0 || selected !== 1'b0 || memAddr !== 8'h00) begin
      n_err++;
      $display("FAIL async_reset: got oe %b cyc %0d sel %b addr %h want 0 0 0 00",
               busOe, cycleOut, selected, memAddr);
    end
    tick();
    rst = 1'b0;
    last_addr = 8'h00;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (busOe !== 1'b0 || cycleOut !== 3'd0) bad++;
    end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL idle_after_reset: got %0d active clocks want 0", bad); end
  endtask

  task automatic test_wrap();
    fetch(12'h011, 1'b1, 1);
    fetch(12'h0FE, 1'b1, 2);
    fetch(12'h080, 1'b1, 2);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i * 29 + 7);
    rom[8'hA5] = 8'h3C;
    test_reset();
    test_basic();
    test_unselected();
    test_back_to_back();
    test_sync_abort();
    test_reset_midfetch();
    test_wrap();
    tick();
    n_vec++;
    if (sbq.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", sbq.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
